ttl_74323: RTL and testbench

//   8-bit universal shift/storage register with synchronous clear and 3-state parallel outputs.

---
 rtl/ttl_74323.sv | 70 +++++++
 tb/tb_ttl_74323.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ttl_74323.sv
`default_nettype none
// ============================================================================
// Module   : ttl_74323
// Brief    : WIDTH-bit universal shift/storage register with synchronous
//            active-low clear, hold / shift-right / shift-left / parallel
//            load modes, 3-state parallel outputs and always-driven serial
//            end taps for cascading.
// Revision : 1.0 - initial release
// ============================================================================
module ttl_74323 #(
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear_bar,
    input  logic [1:0]       S,
    input  logic             DS_right,
    input  logic             DS_left,
    input  logic [WIDTH-1:0] D,
    input  logic             OE1_bar,
    input  logic             OE2_bar,
    output tri   [WIDTH-1:0] Q,
    output logic             Q_first,
    output logic             Q_last
);

    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_RIGHT = 2'b01;
    localparam logic [1:0] c_MODE_LEFT  = 2'b10;
    localparam logic [1:0] c_MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] r_reg;
    logic             w_q_drive;

    // Register update: clear dominates every mode, otherwise S selects the operation.
    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            r_reg <= '0;
        end else begin
            case (S)
                c_MODE_HOLD:  r_reg <= r_reg;
                c_MODE_RIGHT: r_reg <= {r_reg[WIDTH-2:0], DS_right};
                c_MODE_LEFT:  r_reg <= {DS_left, r_reg[WIDTH-1:1]};
                c_MODE_LOAD:  r_reg <= D;
                default:      r_reg <= 'x;
            endcase
        end
    end

    // Bus is driven only with both enables low; a load releases the bus
    // regardless of the enables, because on the real part Q doubles as the
    // load input pins.
    always_comb begin
        w_q_drive = (OE1_bar == 1'b0) && (OE2_bar == 1'b0) && (S != c_MODE_LOAD);
    end

    // The rise/fall delays describe the discrete part's pin timing; in the
    // synthesized register the outputs follow R with no modelled delay, so
    // the parameters are only validated here.
    if (WIDTH >= 2 && DELAY_RISE >= 0 && DELAY_FALL >= 0) begin : g_outputs
        assign Q       = w_q_drive ? r_reg : {WIDTH{1'bz}};
        assign Q_first = r_reg[0];
        assign Q_last  = r_reg[WIDTH-1];
    end else begin : g_bad_params
        $error("ttl_74323: WIDTH must be >= 2 and delays must be non-negative");
    end

endmodule
`default_nettype wire

// File: tb/tb_ttl_74323.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttl_74323
// Brief    : Scoreboard bench for ttl_74323. Stimulus pushes hand-computed
//            expectations; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ttl_74323;

    logic       Clk;
    logic       Clear_bar;
    logic [1:0] S;
    logic       DS_right;
    logic       DS_left;
    logic [7:0] D;
    logic       OE1_bar;
    logic       OE2_bar;
    tri   [7:0] Q;
    logic       Q_first;
    logic       Q_last;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       f;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ttl_74323 #(
        .WIDTH      (8),
        .DELAY_RISE (0),
        .DELAY_FALL (0)
    ) dut (
        .Clk       (Clk),
        .Clear_bar (Clear_bar),
        .S         (S),
        .DS_right  (DS_right),
        .DS_left   (DS_left),
        .D         (D),
        .OE1_bar   (OE1_bar),
        .OE2_bar   (OE2_bar),
        .Q         (Q),
        .Q_first   (Q_first),
        .Q_last    (Q_last)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: outputs are stable mid-cycle, so every pending expectation is
    // compared on the falling edge.
    always @(negedge Clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (Q !== e.q || Q_first !== e.f || Q_last !== e.l) begin
                errors++;
                $display("FAIL %s: got Q=%h first=%b last=%b, expected Q=%h first=%b last=%b",
                         e.name, Q, Q_first, Q_last, e.q, e.f, e.l);
            end
        end
    end

    // Apply inputs, take one rising edge, queue the expected outputs, then
    // hold the inputs until the monitor has sampled them.
    task automatic step(input string nm, input logic clr, input logic [1:0] s,
                        input logic dsr, input logic dsl, input logic [7:0] d,
                        input logic oe1, input logic oe2,
                        input logic [7:0] eq, input logic ef, input logic el);
        exp_t e;
        Clear_bar = clr;
        S         = s;
        DS_right  = dsr;
        DS_left   = dsl;
        D         = d;
        OE1_bar   = oe1;
        OE2_bar   = oe2;
        @(posedge Clk);
        #1;
        e.name = nm;
        e.q    = eq;
        e.f    = ef;
        e.l    = el;
        sb.push_back(e);
        @(negedge Clk);
        #1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] sl_exp [7];
        logic [7:0] zz;
        zz = 8'hzz;
        sl_exp = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

        Clear_bar = 1'b1;
        S         = 2'b00;
        DS_right  = 1'b0;
        DS_left   = 1'b0;
        D         = 8'h00;
        OE1_bar   = 1'b0;
        OE2_bar   = 1'b0;
        @(negedge Clk);
        #1;

        // Clear from unknown state
        step("clear",        1'b0, 2'b00, 0, 0, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0);
        // Load A5: bus released during load, serial taps follow R
        step("load_z",       1'b1, 2'b11, 0, 0, 8'hA5, 0, 0, zz,    1'b1, 1'b1);
        step("load_read",    1'b1, 2'b00, 0, 0, 8'h00, 0, 0, 8'hA5, 1'b1, 1'b1);

        // Clear pulsed low strictly between edges has no effect
        Clear_bar = 1'b0;
        #2;
        Clear_bar = 1'b1;
        step("clr_between",  1'b1, 2'b00, 0, 0, 8'h00, 0, 0, 8'hA5, 1'b1, 1'b1);

        // Shift right with DS_right=0: A5 -> 4A -> 94 -> 28
        step("shr_1",        1'b1, 2'b01, 0, 0, 8'h00, 0, 0, 8'h4A, 1'b0, 1'b0);
        step("shr_2",        1'b1, 2'b01, 0, 0, 8'h00, 0, 0, 8'h94, 1'b0, 1'b1);
        step("shr_3",        1'b1, 2'b01, 0, 0, 8'h00, 0, 0, 8'h28, 1'b0, 1'b0);

        // Shift left from 81 with DS_left=1 fills with ones to FF
        step("load_81",      1'b1, 2'b11, 0, 0, 8'h81, 0, 0, zz,    1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step($sformatf("shl_%0d", i + 1), 1'b1, 2'b10, 0, 1, 8'h00, 0, 0,
                 sl_exp[i], sl_exp[i][0], 1'b1);
        end

        // Output enables gate Q only; serial taps stay driven
        step("load_3c",      1'b1, 2'b11, 0, 0, 8'h3C, 0, 0, zz,    1'b0, 1'b0);
        step("oe_both_on",   1'b1, 2'b00, 0, 0, 8'h00, 0, 0, 8'h3C, 1'b0, 1'b0);
        step("oe1_off",      1'b1, 2'b00, 0, 0, 8'h00, 1, 0, zz,    1'b0, 1'b0);
        step("oe2_off",      1'b1, 2'b00, 0, 0, 8'h00, 0, 1, zz,    1'b0, 1'b0);
        step("oe_both_off",  1'b1, 2'b00, 0, 0, 8'h00, 1, 1, zz,    1'b0, 1'b0);
        step("oe_reenable",  1'b1, 2'b00, 0, 0, 8'h00, 0, 0, 8'h3C, 1'b0, 1'b0);

        // Clear beats load; bus stays released while S=11
        step("load_ff",      1'b1, 2'b11, 0, 0, 8'hFF, 0, 0, zz,    1'b1, 1'b1);
        step("clr_vs_load",  1'b0, 2'b11, 0, 0, 8'hFF, 0, 0, zz,    1'b0, 1'b0);
        step("clr_vs_read",  1'b1, 2'b00, 0, 0, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0);

        // Clear during shift, then shifting resumes from all-zero
        step("load_ff_2",    1'b1, 2'b11, 0, 0, 8'hFF, 0, 0, zz,    1'b1, 1'b1);
        step("clr_in_shift", 1'b0, 2'b01, 1, 0, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0);
        step("shr_after_clr",1'b1, 2'b01, 1, 0, 8'h00, 0, 0, 8'h01, 1'b1, 1'b0);
        step("shr_fill_1",   1'b1, 2'b01, 1, 0, 8'h00, 0, 0, 8'h03, 1'b1, 1'b0);

        // Let the monitor drain the queue
        @(negedge Clk);
        @(negedge Clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
